// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Walks a 4-input combinational circuit through every non-skipped 4-bit
//   code in ascending order. Each code is held for HOLD_CYCLES cycles and
//   then held for one more cycle while the response `s` is sampled into
//   tt_out. Each captured bit is compared with the expected table that was
//   latched at start. The first mismatching code is recorded.
//
// Parameters
//   HOLD_CYCLES : cycles each code is driven before sampling (1..255)
//   SKIP_MASK   : bit i = 1 removes code i from the scan entirely
//
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   start       : scan request, accepted only when idle
//   expected    : expected truth table, latched when start is accepted
//   s           : response of the circuit-under-test
//   a,b,c,d     : registered code drive, a = MSB, d = LSB
//   busy        : scan in progress
//   done        : one-cycle completion pulse
//   tt_out      : captured truth table
//   mismatch    : sticky compare-failure flag
//   err_idx     : first mismatching code, valid when mismatch = 1
module truth_table_scanner #(
  parameter int          HOLD_CYCLES = 10,
  parameter logic [15:0] SKIP_MASK   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_out,
  output logic        mismatch,
  output logic [3:0]  err_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
  localparam logic       ALL_SKIPPED = (SKIP_MASK == 16'hFFFF);

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] exp_q, exp_n;
  logic [15:0] tt_n;
  logic        mis_n;
  logic [3:0]  err_n;
  logic [3:0]  code_q, code_n;
  logic        busy_n, done_n;

  logic [3:0]  first_code;
  logic [3:0]  next_code;
  logic        has_next;
  logic [3:0]  j;

  // Scanning from the top down leaves the lowest qualifying code in place.
  always_comb begin
    first_code = '0;
    next_code  = '0;
    has_next   = 1'b0;
    j          = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      j = 4'(15 - i);
      if (!SKIP_MASK[j]) begin
        first_code = j;
        if (j > idx) begin
          next_code = j;
          has_next  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    exp_n   = exp_q;
    tt_n    = tt_out;
    mis_n   = mismatch;
    err_n   = err_idx;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          exp_n = expected;
          tt_n  = '0;
          mis_n = 1'b0;
          err_n = '0;
          cnt_n = '0;
          if (ALL_SKIPPED) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = first_code;
            state_n = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          state_n = ST_SAMPLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_SAMPLE: begin
        tt_n[idx] = s;
        if ((s != exp_q[idx]) && !mismatch) begin
          mis_n = 1'b1;
          err_n = idx;
        end
        if (has_next) begin
          idx_n   = next_code;
          state_n = ST_DRIVE;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Outputs are registered from the next-state view so the code lands on
    // a..d in the same cycle the FSM enters DRIVE.
    busy_n = (state_n == ST_DRIVE) || (state_n == ST_SAMPLE);
    code_n = busy_n ? idx_n : 4'd0;
    done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cnt      <= '0;
      exp_q    <= '0;
      tt_out   <= '0;
      mismatch <= 1'b0;
      err_idx  <= '0;
      code_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      exp_q    <= exp_n;
      tt_out   <= tt_n;
      mismatch <= mis_n;
      err_idx  <= err_n;
      code_q   <= code_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  assign a = code_q[3];
  assign b = code_q[2];
  assign c = code_q[1];
  assign d = code_q[0];

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner
//   Four scanner instances with different HOLD_CYCLES / SKIP_MASK settings,
//   each wired to a table-driven circuit-under-test (s = cut_tt[{a,b,c,d}]).
module tb_truth_table_scanner;

  // Per-unit settings, unit 0 in the lowest slice.
  localparam logic [127:0] HOLDS = {32'd10, 32'd1, 32'd10, 32'd10};
  localparam logic [63:0]  MASKS = {16'hFFFF, 16'h0000, 16'h0809, 16'h0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v, a_v, b_v, c_v, d_v, busy_v, done_v, mis_v, s_v;
  logic [15:0] exp_v  [4];
  logic [15:0] tt_v   [4];
  logic [15:0] cut_tt [4];
  logic [3:0]  err_v  [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    truth_table_scanner #(
      .HOLD_CYCLES(int'(HOLDS[g*32 +: 32])),
      .SKIP_MASK  (MASKS[g*16 +: 16])
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_v[g]),
      .expected(exp_v[g]),
      .s       (s_v[g]),
      .a       (a_v[g]),
      .b       (b_v[g]),
      .c       (c_v[g]),
      .d       (d_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g]),
      .tt_out  (tt_v[g]),
      .mismatch(mis_v[g]),
      .err_idx (err_v[g])
    );
    assign s_v[g] = cut_tt[g][{a_v[g], b_v[g], c_v[g], d_v[g]}];
  end

  typedef struct {
    int          unit;
    logic [15:0] cut;
    logic [15:0] expv;
    logic [15:0] tt;
    logic        mis;
    logic [3:0]  err;
    int          pulse;
  } vec_t;

  vec_t vec [8];

  function automatic int hold_of(input int u);
    return int'(HOLDS[u*32 +: 32]);
  endfunction

  function automatic logic [15:0] mask_of(input int u);
    return MASKS[u*16 +: 16];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] code_of(input int u);
    return {a_v[u], b_v[u], c_v[u], d_v[u]};
  endfunction

  // Reference results from the table rules: skipped bits read 0 and are
  // never compared; err is the lowest differing non-skipped code.
  task automatic model(input int u, input logic [15:0] cut, input logic [15:0] expv,
                       output logic [15:0] tt, output logic mis, output logic [3:0] err);
    logic [15:0] diff;
    tt   = cut & ~mask_of(u);
    diff = (cut ^ expv) & ~mask_of(u);
    mis  = (diff != 16'h0);
    err  = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (diff[i]) err = 4'(i);
  endtask

  task automatic run_scan(input int u, input logic [15:0] cut, input logic [15:0] expv,
                          input logic [15:0] tt_e, input logic mis_e, input logic [3:0] err_e,
                          input int pulse_at);
    int codes[$];
    int h, n, total;
    logic [5:0] req;
    h = hold_of(u);
    for (int i = 0; i < 16; i++)
      if (!mask_of(u)[i]) codes.push_back(i);
    n = codes.size();
    total = n * (h + 1) + 1;
    cut_tt[u] = cut;
    exp_v[u]  = expv;
    @(negedge clk);
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    exp_v[u]   = ~expv;
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(negedge clk);
      start_v[u] = (cyc == pulse_at);
      if (cyc < total) req = {4'(codes[(cyc - 1) / (h + 1)]), 1'b1, 1'b0};
      else             req = {4'd0, 1'b0, 1'b1};
      check("cycle", {26'd0, code_of(u), busy_v[u], done_v[u]}, {26'd0, req});
    end
    @(negedge clk);
    start_v[u] = 1'b0;
    check("after_done", {30'd0, busy_v[u], done_v[u]}, 32'd0);
    check("tt_out", {16'd0, tt_v[u]}, {16'd0, tt_e});
    check("mismatch", {31'd0, mis_v[u]}, {31'd0, mis_e});
    check("err_idx", {28'd0, err_v[u]}, {28'd0, err_e});
  endtask

  initial begin
    logic [15:0] cut, expv, tt_e;
    logic        mis_e;
    logic [3:0]  err_e;
    int          u;

    vec[0] = '{0, 16'h8000, 16'h8000, 16'h8000, 1'b0, 4'd0, -1};
    vec[1] = '{0, 16'h8000, 16'h8001, 16'h8000, 1'b1, 4'd0, -1};
    vec[2] = '{0, 16'h8000, 16'h8003, 16'h8000, 1'b1, 4'd0, 40};
    vec[3] = '{1, 16'h6996, 16'h6196, 16'h6196, 1'b0, 4'd0, -1};
    vec[4] = '{2, 16'h8000, 16'h8000, 16'h8000, 1'b0, 4'd0, -1};
    vec[5] = '{3, 16'h8000, 16'h8000, 16'h0000, 1'b0, 4'd0, -1};
    vec[6] = '{0, 16'h1234, 16'h1230, 16'h1234, 1'b1, 4'd2, 177};
    vec[7] = '{1, 16'hFFFF, 16'h0000, 16'hF7F6, 1'b1, 4'd1, -1};

    rst     = 1'b1;
    start_v = '0;
    for (int i = 0; i < 4; i++) begin
      exp_v[i]  = '0;
      cut_tt[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("reset_ctrl", {25'd0, code_of(i), busy_v[i], done_v[i], mis_v[i]}, 32'd0);
      check("reset_data", {12'd0, tt_v[i], err_v[i]}, 32'd0);
    end

    for (int i = 0; i < 8; i++)
      run_scan(vec[i].unit, vec[i].cut, vec[i].expv, vec[i].tt, vec[i].mis, vec[i].err,
               vec[i].pulse);

    // Reset while code 5 is driven on unit 0.
    cut_tt[0] = 16'hFFFF;
    exp_v[0]  = 16'hFFFE;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (59) @(negedge clk);
    check("pre_rst_code", {28'd0, code_of(0)}, 32'd5);
    check("pre_rst_tt", {16'd0, tt_v[0]}, 32'h001F);
    check("pre_rst_mis", {31'd0, mis_v[0]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ctrl", {25'd0, code_of(0), busy_v[0], done_v[0], mis_v[0]}, 32'd0);
    check("rst_data", {12'd0, tt_v[0], err_v[0]}, 32'd0);
    run_scan(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 4'd0, -1);

    for (int r = 0; r < 6; r++) begin
      u    = int'($urandom_range(0, 2));
      cut  = 16'($urandom);
      expv = cut ^ 16'($urandom & $urandom & $urandom);
      model(u, cut, expv, tt_e, mis_e, err_e);
      run_scan(u, cut, expv, tt_e, mis_e, err_e, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
